control_unit: RTL and testbench
===============================

# control_unit

Instruction sequencer for the 5-bit accumulator datapath (data-bus driver, ALU, accumulator, result driver). It fetches 16-bit instruction words from an external asynchronous program ROM and decodes each into the ALU function code and enable strobes. It latches the ALU carry/zero flags and resolves conditional jumps. It sits between the program ROM and the datapath top level and is the only source of datapath control.

## Interface
- PC_W, 12, program counter / ROM address width
- DATA_W, 5, datapath operand width
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- run  in  1  level; 1 = execute, 0 = pause at the next instruction boundary
- instr  in  16  ROM data for address pc, combinational; op = instr[15:12], target = instr[PC_W-1:0], imm = instr[DATA_W-1:0]
- C  in  1  ALU carry/borrow
- ZE  in  1  ALU zero
- pc  out  PC_W  program address
- F  out  3  ALU function code
- imm  out  DATA_W  operand for the data-bus driver
- enableDB  out  1  data-bus driver enable
- enableALU  out  1  accumulator load
- enableR  out  1  result-bus driver enable
- cf, zf  out  1 each  latched flags
- busy  out  1  state is FETCH or EXEC
- halted  out  1  state is HALT
- err  out  1  illegal opcode seen

## Operation
- Reset values: state IDLE, pc 0, IR 0, cf/zf/err 0, all enables 0, F 000, imm 0.
- States:
  - IDLE: if run=1, go to FETCH.
  - FETCH: capture instr into IR at the clock edge; go to EXEC.
  - EXEC: control outputs are decoded from IR. At the edge, update pc and flags. Then go to FETCH if run=1, else IDLE.
  - HALT: holds. When run=0, go to IDLE with pc←0 and err←0.
- Opcode actions (enables not listed are 0):
  - 0 NOP: no action.
  - 1 LIT: F=010, enableDB, enableALU.
  - 2 ADD: F=011, enableDB, enableALU.
  - 3 SUB: F=001, enableDB, enableALU.
  - 4 NAND: F=100, enableDB, enableALU.
  - 5 CMP: F=001, enableDB, flags only, no accumulator load.
  - 6 OUT: F=000, enableR.
  - 7 JMP: jump to target.
  - 8 JZ: jump if zf=1.
  - 9 JNZ: jump if zf=0.
  - A JC: jump if cf=1.
  - B JNC: jump if cf=0.
  - C HALT: go to HALT.
  - D–F illegal: go to HALT, err←1; no enables asserted.
- Flags: cf←C and zf←ZE, latched at the end of EXEC for opcodes 1–5 only. All other opcodes leave the flags unchanged.
- Conditional jumps read the latched flags, never the live C/ZE inputs.
- PC update at the end of EXEC: pc←target when a jump is taken, otherwise pc+1 modulo 2^PC_W (0xFFF wraps to 0x000).
  - HALT and illegal opcodes leave pc unchanged.
- Outputs are Moore: a function of state and IR only. Outside EXEC, all enables are 0, F=000, imm=0.

## Timing
- Every instruction takes exactly 2 cycles (FETCH, EXEC); there is no pipelining.
- Each enable strobe is high for exactly the one EXEC cycle.
- instr must be valid during FETCH for the pc presented in that cycle.
- pc is stable through FETCH and EXEC and changes only at the edge that ends EXEC.
- run is sampled only in IDLE, at the end of EXEC, and in HALT. Dropping run mid-instruction completes that instruction.
- Pause/resume keeps pc, so execution continues at the next instruction.
- Reset asserted mid-EXEC: outputs go to reset values immediately. A partially strobed accumulator load is the datapath's concern.
- Latency from run=1 in IDLE to the first EXEC strobe is 2 cycles.

## Structure
- Package control_pkg holds:
  - opcode constants (OP_NOP … OP_HALT);
  - ALU codes F_PASS_A=000, F_SUB=001, F_PASS_B=010, F_ADD=011, F_NAND=100;
  - state encoding IDLE=00, FETCH=01, EXEC=10, HALT=11.
- Sub-module instr_decoder (combinational) maps IR[15:12] plus the latched flags to F, the enables, the flag-write flag, jump_taken, halt and illegal.
- Top-level FSM, pc, IR and flag registers live in control_unit.

## Test plan
- Reset mid-EXEC of ADD at pc=4: reset low → enables 0, pc=0, state IDLE immediately. Release with run=1 → fetch from 0x000.
- Program LIT 7; ADD 2; OUT; HALT with an ALU/accumulator model:
  - enableR high in cycle 6 only, result bus = 9;
  - halted=1 after cycle 8, pc=3.
- LIT 3; CMP 3; JZ 0x020: zf=1, next pc=0x020. Repeat with CMP 2: zf=0, next pc=3.
- LIT 31; ADD 1; JC 0x100: cf=1, zf=1, jump taken. Repeat with JNC: pc=3.
- Illegal opcode 0xE at pc=5: no enables, halted=1, err=1, pc=5. run=0 → IDLE, pc=0, err=0.
- run dropped during EXEC at pc=0xFFF (NOP) → IDLE, pc=0x000. run=1 → FETCH at 0x000.

Source files
------------

// File: rtl/control_pkg.sv
// control_pkg: opcodes, ALU function codes and FSM state encoding shared by control_unit and instr_decoder
package control_pkg;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LIT  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_NAND = 4'h4;
    localparam logic [3:0] OP_CMP  = 4'h5;
    localparam logic [3:0] OP_OUT  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_JZ   = 4'h8;
    localparam logic [3:0] OP_JNZ  = 4'h9;
    localparam logic [3:0] OP_JC   = 4'hA;
    localparam logic [3:0] OP_JNC  = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hC;
    localparam logic [2:0] F_PASS_A = 3'b000;
    localparam logic [2:0] F_SUB    = 3'b001;
    localparam logic [2:0] F_PASS_B = 3'b010;
    localparam logic [2:0] F_ADD    = 3'b011;
    localparam logic [2:0] F_NAND   = 3'b100;
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        EXEC  = 2'b10,
        HALT  = 2'b11
    } state_t;
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational opcode decode into ALU code, strobes, flag write, jump resolution, halt and illegal
// ports: op (IR[15:12]), cf/zf (latched flags) in; f, en_db, en_alu, en_r, flag_we, jump_taken, halt, illegal out
module instr_decoder
    import control_pkg::*;
(
    input  logic [3:0] op,
    input  logic       cf,
    input  logic       zf,
    output logic [2:0] f,
    output logic       en_db,
    output logic       en_alu,
    output logic       en_r,
    output logic       flag_we,
    output logic       jump_taken,
    output logic       halt,
    output logic       illegal
);
    always_comb begin
        en_alu     = op inside {OP_LIT, OP_ADD, OP_SUB, OP_NAND};
        en_db      = en_alu || op == OP_CMP;
        flag_we    = en_db;
        en_r       = op == OP_OUT;
        f          = op == OP_LIT ? F_PASS_B :
                     op == OP_ADD ? F_ADD :
                     (op == OP_SUB || op == OP_CMP) ? F_SUB :
                     op == OP_NAND ? F_NAND : F_PASS_A;
        jump_taken = op == OP_JMP || (op == OP_JZ && zf) || (op == OP_JNZ && !zf) ||
                     (op == OP_JC && cf) || (op == OP_JNC && !cf);
        halt       = op == OP_HALT;
        illegal    = op > OP_HALT;
    end
endmodule

// File: rtl/control_unit.sv
// control_unit: two-cycle FETCH/EXEC sequencer driving the accumulator datapath from a 16-bit program ROM
// ports: clk, reset (async active-low), run, instr, C, ZE in; pc, F, imm, enableDB, enableALU, enableR,
//        cf, zf, busy, halted, err out
module control_unit
    import control_pkg::*;
#(
    parameter int PC_W   = 12,
    parameter int DATA_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [15:0]       instr,
    input  logic              C,
    input  logic              ZE,
    output logic [PC_W-1:0]   pc,
    output logic [2:0]        F,
    output logic [DATA_W-1:0] imm,
    output logic              enableDB,
    output logic              enableALU,
    output logic              enableR,
    output logic              cf,
    output logic              zf,
    output logic              busy,
    output logic              halted,
    output logic              err
);
    state_t state, next_state;
    logic [15:0] ir;
    logic [2:0] d_f;
    logic d_db, d_alu, d_r, d_fwe, d_jump, d_halt, d_ill;
    instr_decoder u_dec (
        .op(ir[15:12]),
        .cf(cf),
        .zf(zf),
        .f(d_f),
        .en_db(d_db),
        .en_alu(d_alu),
        .en_r(d_r),
        .flag_we(d_fwe),
        .jump_taken(d_jump),
        .halt(d_halt),
        .illegal(d_ill)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = run ? FETCH : IDLE;
            FETCH:   next_state = EXEC;
            EXEC:    next_state = (d_halt || d_ill) ? HALT : run ? FETCH : IDLE;
            default: next_state = run ? HALT : IDLE;
        endcase
    end
    // pc only moves at the edge ending EXEC (or the HALT->IDLE restart), so it is stable for the whole instruction
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc  <= '0;
            ir  <= '0;
            cf  <= 1'b0;
            zf  <= 1'b0;
            err <= 1'b0;
        end else begin
            if (state == FETCH) ir <= instr;
            if (state == EXEC && d_fwe) begin
                cf <= C;
                zf <= ZE;
            end
            if (state == EXEC && d_ill) err <= 1'b1;
            if (state == EXEC && !d_halt && !d_ill) pc <= d_jump ? ir[PC_W-1:0] : pc + PC_W'(1);
            if (state == HALT && !run) begin
                pc  <= '0;
                err <= 1'b0;
            end
        end
    end
    always_comb begin
        F         = state == EXEC ? d_f : F_PASS_A;
        enableDB  = state == EXEC && d_db;
        enableALU = state == EXEC && d_alu;
        enableR   = state == EXEC && d_r;
        imm       = state == EXEC ? ir[DATA_W-1:0] : '0;
        busy      = state == FETCH || state == EXEC;
        halted    = state == HALT;
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench with an instruction-level reference model and an accumulator datapath model
module tb_control_unit;
    typedef struct packed {
        logic [11:0] pc;
        logic [2:0]  f;
        logic        db, alu, r;
        logic [4:0]  imm, res;
        logic [11:0] npc;
        logic        ncf, nzf, nhalt, nerr;
    } exp_t;
    logic clk = 0, reset, run;
    logic [15:0] instr;
    logic alu_c, alu_z;
    logic [11:0] pc;
    logic [2:0] F;
    logic [4:0] imm;
    logic enableDB, enableALU, enableR, cf, zf, busy, halted, err;
    logic [15:0] rom [4096];
    logic [4:0] acc, bus_b, alu_r;
    int n_chk = 0, n_pass = 0, popped = 0;
    logic mon_en = 0, phase = 0, pend = 0, ex;
    exp_t q[$];
    exp_t pe;
    logic [11:0] m_pc;
    logic [4:0] m_acc;
    logic m_cf, m_zf, m_halt, m_err;
    control_unit dut (
        .clk(clk), .reset(reset), .run(run), .instr(instr), .C(alu_c), .ZE(alu_z),
        .pc(pc), .F(F), .imm(imm), .enableDB(enableDB), .enableALU(enableALU), .enableR(enableR),
        .cf(cf), .zf(zf), .busy(busy), .halted(halted), .err(err)
    );
    always #5 clk = ~clk;
    assign instr = rom[pc];
    always_comb begin
        bus_b = enableDB ? imm : 5'd0;
        {alu_c, alu_r} = {1'b0, acc};
        case (F)
            3'b001:  {alu_c, alu_r} = {1'b0, acc} - {1'b0, bus_b};
            3'b010:  {alu_c, alu_r} = {1'b0, bus_b};
            3'b011:  {alu_c, alu_r} = {1'b0, acc} + {1'b0, bus_b};
            3'b100:  {alu_c, alu_r} = {1'b0, ~(acc & bus_b)};
            default: ;
        endcase
        alu_z = alu_r == 5'd0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) acc <= '0;
        else if (enableALU) acc <= alu_r;
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (pc %0h)", nm, act, exp, pc);
    endtask
    task automatic fail_to(input string nm);
        n_chk++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask
    // Executes up to k instructions at ISA level and queues what each EXEC cycle must look like
    task automatic model_prog(input int k, output int n);
        n = 0;
        for (int i = 0; i < k; i++) begin
            exp_t e;
            logic [15:0] w;
            int a, b, v;
            logic c, fl, tk;
            w = rom[m_pc];
            a = m_acc;
            b = w[4:0];
            v = 0; c = 0; fl = 0; tk = 0;
            e = '0;
            e.pc = m_pc;
            e.imm = w[4:0];
            case (w[15:12])
                4'h1: begin e.f = 3'b010; e.db = 1; e.alu = 1; v = b; fl = 1; end
                4'h2: begin e.f = 3'b011; e.db = 1; e.alu = 1; v = a + b; c = v > 31; fl = 1; end
                4'h3: begin e.f = 3'b001; e.db = 1; e.alu = 1; v = a - b; c = a < b; fl = 1; end
                4'h4: begin e.f = 3'b100; e.db = 1; e.alu = 1; v = ~(a & b); fl = 1; end
                4'h5: begin e.f = 3'b001; e.db = 1; v = a - b; c = a < b; fl = 1; end
                4'h6: begin e.r = 1; e.res = m_acc; end
                4'h7: tk = 1;
                4'h8: tk = m_zf;
                4'h9: tk = !m_zf;
                4'hA: tk = m_cf;
                4'hB: tk = !m_cf;
                default: ;
            endcase
            if (fl) begin
                m_cf = c;
                m_zf = (v & 31) == 0;
            end
            if (e.alu) m_acc = 5'(v & 31);
            m_halt = w[15:12] >= 4'hC;
            if (w[15:12] > 4'hC) m_err = 1;
            if (!m_halt) m_pc = tk ? w[11:0] : m_pc + 12'd1;
            e.npc = m_pc; e.ncf = m_cf; e.nzf = m_zf; e.nhalt = m_halt; e.nerr = m_err;
            q.push_back(e);
            n++;
            if (m_halt) break;
        end
    endtask
    task automatic run_prog(input int k);
        int n, tgt, cyc;
        model_prog(k, n);
        tgt = popped + n;
        cyc = 0;
        run = 1;
        while (popped < tgt && cyc < 3000) begin
            @(negedge clk);
            #2;
            cyc++;
            run = popped >= tgt ? 1'b0 : $urandom_range(0, 7) != 0;
        end
        if (popped < tgt) begin
            fail_to("program");
            q.delete();
        end
        run = 0;
        if (m_halt) begin
            m_pc = 0; m_err = 0; m_halt = 0;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_halted", halted, 0);
        chk("idle_pc", pc, m_pc);
        chk("idle_err", err, 0);
    endtask
    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 16'h0000;
    endtask
    always @(negedge clk) begin
        if (!mon_en) begin
            phase = 0;
            pend = 0;
        end else begin
            if (pend) begin
                chk("post_pc", pc, pe.npc);
                chk("post_cf", cf, pe.ncf);
                chk("post_zf", zf, pe.nzf);
                chk("post_halted", halted, pe.nhalt);
                chk("post_err", err, pe.nerr);
                pend = 0;
            end
            ex = busy && phase;
            phase = busy && !phase;
            if (ex) begin
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_exec: EXEC at pc %0h with nothing expected", pc);
                end else begin
                    pe = q.pop_front();
                    popped++;
                    chk("exec_pc", pc, pe.pc);
                    chk("exec_f", F, pe.f);
                    chk("exec_en", {enableDB, enableALU, enableR}, {pe.db, pe.alu, pe.r});
                    if (pe.db) chk("exec_imm", imm, pe.imm);
                    if (pe.r) chk("out_result", acc, pe.res);
                    pend = 1;
                end
            end else begin
                chk("non_exec_ctrl", {F, enableDB, enableALU, enableR, imm}, 0);
            end
        end
    end
    initial begin
        int cyc;
        reset = 0;
        run = 0;
        clear_rom();
        repeat (2) @(negedge clk);
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_flags", {cf, zf, err}, 0);
        chk("rst_ctrl", {F, enableDB, enableALU, enableR, imm}, 0);
        rom[4] = 16'h2005;
        reset = 1;
        run = 1;
        cyc = 0;
        while (!enableDB && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        if (!enableDB) fail_to("reach_add");
        chk("add_pc", pc, 4);
        chk("add_alu", enableALU, 1);
        #1 reset = 0;
        #1;
        chk("midexec_en", {enableDB, enableALU, enableR}, 0);
        chk("midexec_pc", pc, 0);
        chk("midexec_busy", busy, 0);
        @(negedge clk);
        reset = 1;
        cyc = 0;
        while (!busy && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        if (!busy) fail_to("refetch");
        chk("refetch_pc", pc, 0);
        run = 0;
        repeat (4) @(negedge clk);
        reset = 0;
        @(negedge clk);
        reset = 1;
        m_pc = 0; m_acc = 0; m_cf = 0; m_zf = 0; m_halt = 0; m_err = 0;
        mon_en = 1;
        clear_rom();
        rom[0] = 16'h1007; rom[1] = 16'h2002; rom[2] = 16'h6000; rom[3] = 16'hC000;
        run_prog(10);
        clear_rom();
        rom[0] = 16'h1003; rom[1] = 16'h5003; rom[2] = 16'h8020; rom[12'h020] = 16'hC000;
        run_prog(10);
        rom[1] = 16'h5002; rom[3] = 16'hC000;
        run_prog(10);
        clear_rom();
        rom[0] = 16'h101F; rom[1] = 16'h2001; rom[2] = 16'hA100; rom[12'h100] = 16'hC000;
        run_prog(10);
        rom[2] = 16'hB100; rom[3] = 16'hC000;
        run_prog(10);
        clear_rom();
        rom[5] = 16'hE000;
        run_prog(10);
        clear_rom();
        rom[0] = 16'h7FFF;
        run_prog(2);
        for (int p = 0; p < 15; p++) begin
            for (int i = 0; i < 4096; i++) begin
                int r;
                r = $urandom_range(0, 99);
                rom[i] = {r < 94 ? 4'($urandom_range(0, 11)) : 4'($urandom_range(12, 15)), 12'($urandom)};
            end
            run_prog(30);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
